rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: width of each requester address and of the shared ROM address.
REQ-002 Parameter DATA_W, default 12: ROM word width (4:4:4 RGB pixel).
REQ-003 Parameter ROM_LAT, default 1, legal range 1..4: cycles from rom_addr/rom_en to valid rom_data.
REQ-004 clk  input  1: single clock (65 MHz pixel clock domain), all logic on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 req  input  3: per-requester access request, bit i = requester i.
REQ-007 addr  input  3*ADDR_W: packed requester addresses, slice i = addr[i*ADDR_W +: ADDR_W].
REQ-008 gnt  output  3: one-hot grant pulse, meaning the request was accepted this cycle.
REQ-009 rvalid  output  3: one-hot read-data-valid tag.
REQ-010 rdata  output  DATA_W: read data, shared by all requesters, qualified by rvalid.
REQ-011 rom_en  output  1: ROM read enable.
REQ-012 rom_addr  output  ADDR_W: ROM address.
REQ-013 rom_data  input  DATA_W: ROM read data, valid ROM_LAT cycles after rom_en.

Function
REQ-014 Arbitration shall run every cycle; at most one requester is selected per cycle.
REQ-015 Selection shall be round-robin: search order starts at (last_winner+1) mod 3 and wraps; after reset last_winner = 2, so requester 0 has first priority.
REQ-016 last_winner shall update only in cycles where a grant is issued; idle cycles preserve it.
REQ-017 A request sampled at edge t (req[i]=1, winner i) shall produce, registered and valid after edge t: gnt[i]=1 for one cycle, rom_en=1, rom_addr=addr slice i as sampled at t.
REQ-018 Requesters shall hold req and addr stable until gnt; a requester holding req after gnt is a new request and competes again the next cycle.
REQ-019 A single active requester shall be granted every cycle (full throughput, no bubbles).
REQ-020 With all three requesting continuously, grants shall rotate 0,1,2,0,... with no requester waiting more than 2 cycles.
REQ-021 When no req bit is set, gnt=0 and rom_en=0; rom_addr shall hold its last value.
REQ-022 A tag pipeline of ROM_LAT stages shall carry the one-hot gnt; rvalid[i]=1 with rdata=rom_data exactly ROM_LAT cycles after the corresponding gnt[i] pulse (rdata combinational from rom_data or registered with ROM alignment, latency as stated).
REQ-023 Responses shall return in grant order; back-to-back grants yield back-to-back rvalid pulses.
REQ-024 rvalid shall be zero-hot whenever no grant occurred ROM_LAT cycles earlier; rdata is don't-care then.
REQ-025 gnt, rvalid each shall be one-hot or zero at all times.

Reset
REQ-026 While rst=1: gnt=0, rvalid=0, rom_en=0, rom_addr=0, rdata=0, tag pipeline cleared, last_winner=2.
REQ-027 Reset asserted mid-operation shall discard all in-flight tags; no rvalid shall appear for grants issued before reset.
REQ-028 First edge after rst deasserts shall arbitrate normally (requester 0 wins ties).

Verification
REQ-029 Reset release, req=3'b111 held, addr slices 0x010/0x020/0x030 -> gnt 001,010,100,001...; rom_addr 0x010,0x020,0x030 on consecutive cycles.
REQ-030 ROM_LAT=1, model ROM returns data=addr, single req[1]=1 for 4 cycles at addr 0x0A5 -> gnt[1] 4 consecutive cycles, rvalid[1] 4 consecutive cycles one cycle later, rdata=0x0A5.
REQ-031 ROM_LAT=3, req[2] pulse then req[0] pulse next cycle -> rvalid=100 then 001 exactly 3 cycles after each gnt, rdata matching each address.
REQ-032 Grant to 1, idle 5 cycles, then req=3'b011 -> requester 0 wins first (pointer preserved after 1), then 1.
REQ-033 Grants in flight with ROM_LAT=2, assert rst one cycle -> all outputs 0 immediately, no rvalid after release, next req=3'b110 grants requester 1 first.
REQ-034 Random req/addr for 10k cycles -> gnt and rvalid one-hot/zero, each gnt matched by one rvalid after ROM_LAT, no requester starved beyond 2 cycles.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester/ROM bus bundle for the three-way ROM arbiter
// Purpose : groups the requester handshake and the ROM port into one bundle.
// Signals : req/addr (requests in), gnt/rvalid/rdata (grants and read data out),
//           rom_en/rom_addr (ROM command out), rom_data (ROM read data in).
// Modports: slave  - arbiter side
//           master - environment side (requesters plus ROM)
interface rom_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic [2:0]          req;
    logic [3*ADDR_W-1:0] addr;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                rom_en;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data;

    modport slave (
        input  req, addr, rom_data,
        output gnt, rvalid, rdata, rom_en, rom_addr
    );

    modport master (
        output req, addr, rom_data,
        input  gnt, rvalid, rdata, rom_en, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one ROM read port among three requesters
// Purpose : picks at most one requester per cycle in round-robin order, issues the
//           ROM read, and returns the read data tagged with the winner ROM_LAT
//           cycles later.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - rom_arbiter_if.slave (req/addr in, gnt/rvalid/rdata out,
//                 rom_en/rom_addr out, rom_data in)
module rom_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    rom_arbiter_if.slave  bus
);

    logic [1:0]              last_q, last_d;
    logic [2:0]              gnt_q, gnt_d;
    logic                    rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    // One one-hot tag per ROM pipeline stage; the last stage lines up with rom_data.
    logic [ROM_LAT-1:0][2:0] tag_q;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Search starts one past the last winner and wraps; first requester found wins.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        gnt_d      = '0;
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        found      = 1'b0;
        idx        = inc3(last_q);
        for (int k = 0; k < 3; k++) begin
            if (!found && bus.req[idx]) begin
                found      = 1'b1;
                gnt_d[idx] = 1'b1;
                last_d     = idx;
                rom_addr_d = bus.addr[idx*ADDR_W +: ADDR_W];
            end
            idx = inc3(idx);
        end
        rom_en_d = found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 2'd2;
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            tag_q      <= '0;
        end else begin
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            tag_q[0]   <= gnt_q;
            for (int s = ROM_LAT - 1; s > 0; s--) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rvalid   = tag_q[ROM_LAT-1];
    // Data passes straight through from the ROM; forced to zero when no tag is valid
    // so rdata is clean during reset and idle cycles.
    assign bus.rdata    = (|tag_q[ROM_LAT-1]) ? bus.rom_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed and randomized checks of rom_arbiter at ROM_LAT 1, 2 and 3
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [35:0] addr = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0]  hg[4];
    logic [11:0] ha[4];
    logic [11:0] rp1[1];
    logic [11:0] rp2[2];
    logic [11:0] rp3[3];

    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(12), .DATA_W(12)) if1 ();
    rom_arbiter_if #(.ADDR_W(12), .DATA_W(12)) if2 ();
    rom_arbiter_if #(.ADDR_W(12), .DATA_W(12)) if3 ();

    assign if1.req = req;  assign if1.addr = addr;  assign if1.rom_data = rp1[0];
    assign if2.req = req;  assign if2.addr = addr;  assign if2.rom_data = rp2[1];
    assign if3.req = req;  assign if3.addr = addr;  assign if3.rom_data = rp3[2];

    rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
    rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(2)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
    rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(3)) u_l3 (.clk(clk), .rst(rst), .bus(if3));

    // Model ROMs return data = address, with 1, 2 and 3 cycles of latency.
    always @(posedge clk) begin
        rp1[0] <= if1.rom_addr;
        rp2[0] <= if2.rom_addr;
        rp2[1] <= rp2[0];
        rp3[0] <= if3.rom_addr;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 4; k++) begin
            hg[k] = '0;
            ha[k] = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt1"},  if1.gnt, 0);     check({tag, "_rv1"}, if1.rvalid, 0);
        check({tag, "_gnt2"},  if2.gnt, 0);     check({tag, "_rv2"}, if2.rvalid, 0);
        check({tag, "_gnt3"},  if3.gnt, 0);     check({tag, "_rv3"}, if3.rvalid, 0);
        check({tag, "_en"},    if1.rom_en, 0);  check({tag, "_addr"}, if1.rom_addr, 0);
        check({tag, "_rd1"},   if1.rdata, 0);   check({tag, "_rd3"}, if3.rdata, 0);
    endtask

    // One clock: drive inputs, then check grant/address against the hand-computed
    // values and rvalid/rdata against what was expected ROM_LAT cycles ago.
    task automatic do_cycle(input logic [2:0] r, input logic [11:0] a0, input logic [11:0] a1,
                            input logic [11:0] a2, input logic [2:0] eg, input logic [11:0] ea);
        req  = r;
        addr = {a2, a1, a0};
        @(posedge clk);
        #1;
        for (int k = 3; k > 0; k--) begin
            hg[k] = hg[k-1];
            ha[k] = ha[k-1];
        end
        hg[0] = eg;
        ha[0] = ea;
        check("gnt_l1", if1.gnt, eg);
        check("gnt_l2", if2.gnt, eg);
        check("gnt_l3", if3.gnt, eg);
        check("rom_en", if1.rom_en, |eg);
        check("rom_addr", if1.rom_addr, ea);
        check("rvalid_l1", if1.rvalid, hg[1]);
        check("rvalid_l2", if2.rvalid, hg[2]);
        check("rvalid_l3", if3.rvalid, hg[3]);
        if (hg[1] != 0) check("rdata_l1", if1.rdata, ha[1]);
        if (hg[2] != 0) check("rdata_l2", if2.rdata, ha[2]);
        if (hg[3] != 0) check("rdata_l3", if3.rdata, ha[3]);
    endtask

    task automatic idle(input int n, input logic [11:0] ea);
        for (int i = 0; i < n; i++) do_cycle(3'b000, 12'h0, 12'h0, 12'h0, 3'b000, ea);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        req = '0;
        #1;
        check_zero(tag);
        @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b0;
        clear_hist();
    endtask

    initial begin
        int          m_last;
        logic [11:0] m_addr;
        logic [2:0]  pend;
        logic [11:0] pa[3];
        int          wcnt[3];
        logic [2:0]  eg;
        logic [11:0] ea;
        bit          found;

        clear_hist();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Three-way contention after reset: rotation starts at requester 0.
        do_cycle(3'b111, 12'h010, 12'h020, 12'h030, 3'b001, 12'h010);
        do_cycle(3'b111, 12'h010, 12'h020, 12'h030, 3'b010, 12'h020);
        do_cycle(3'b111, 12'h010, 12'h020, 12'h030, 3'b100, 12'h030);
        do_cycle(3'b111, 12'h010, 12'h020, 12'h030, 3'b001, 12'h010);
        idle(2, 12'h010);

        // Single requester streams at full rate.
        for (int i = 0; i < 4; i++) do_cycle(3'b010, 12'h0, 12'h0A5, 12'h0, 3'b010, 12'h0A5);
        idle(5, 12'h0A5);

        // Pointer preserved across idle cycles: after 1, requester 0 beats 1.
        do_cycle(3'b011, 12'h100, 12'h111, 12'h0, 3'b001, 12'h100);
        do_cycle(3'b010, 12'h100, 12'h111, 12'h0, 3'b010, 12'h111);

        // Back-to-back single pulses return in grant order.
        do_cycle(3'b100, 12'h0,   12'h0, 12'h2C2, 3'b100, 12'h2C2);
        do_cycle(3'b001, 12'h3C3, 12'h0, 12'h0,   3'b001, 12'h3C3);
        idle(4, 12'h3C3);

        // Two-way contention alternates.
        do_cycle(3'b101, 12'h0E0, 12'h0, 12'h0E2, 3'b100, 12'h0E2);
        do_cycle(3'b101, 12'h0E0, 12'h0, 12'h0E2, 3'b001, 12'h0E0);
        do_cycle(3'b101, 12'h0E0, 12'h0, 12'h0E2, 3'b100, 12'h0E2);
        do_cycle(3'b101, 12'h0E0, 12'h0, 12'h0E2, 3'b001, 12'h0E0);
        idle(1, 12'h0E0);

        // Reset with grants in flight: nothing may come back afterwards.
        do_cycle(3'b111, 12'h410, 12'h420, 12'h430, 3'b010, 12'h420);
        do_cycle(3'b111, 12'h410, 12'h420, 12'h430, 3'b100, 12'h430);
        pulse_reset("midrst");
        idle(4, 12'h000);
        do_cycle(3'b110, 12'h0, 12'h5A5, 12'h6A6, 3'b010, 12'h5A5);
        do_cycle(3'b100, 12'h0, 12'h5A5, 12'h6A6, 3'b100, 12'h6A6);
        idle(4, 12'h6A6);

        // Randomized traffic with requesters that hold until granted.
        pulse_reset("rndrst");
        m_last = 2;
        m_addr = '0;
        pend   = '0;
        for (int i = 0; i < 3; i++) begin
            pa[i]   = '0;
            wcnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    pa[i]   = 12'($urandom_range(0, 4095));
                end
            end
            eg    = '0;
            ea    = m_addr;
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                int w;
                w = (m_last + k) % 3;
                if (!found && pend[w]) begin
                    found  = 1'b1;
                    eg[w]  = 1'b1;
                    ea     = pa[w];
                    m_last = w;
                end
            end
            m_addr = ea;
            do_cycle(pend, pa[0], pa[1], pa[2], eg, ea);
            check("gnt_onehot", 32'($onehot0(if1.gnt)), 1);
            check("rv1_onehot", 32'($onehot0(if1.rvalid)), 1);
            check("rv3_onehot", 32'($onehot0(if3.rvalid)), 1);
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && !if1.gnt[i]) wcnt[i]++;
                else                        wcnt[i] = 0;
                check("starve", 32'(wcnt[i] > 2), 0);
                if (eg[i]) pend[i] = 1'b0;
            end
        end
        idle(4, m_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
